// File: rtl/spi_frame_pkg.sv
// Shared types and sizing helpers for the SPI frame decoder.
// Imported by the decoder top and its edge-detect sub-module.
package spi_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } state_e;

    function automatic int frame_w(input int field_w, input int num_fields);
        return field_w * num_fields;
    endfunction

    // Counter must reach FRAME_W+1 so long frames stay distinguishable.
    function automatic int cnt_w(input int fw);
        return $clog2(fw + 2);
    endfunction

endpackage

// File: rtl/spi_frame_decoder_if.sv
// SPI pins plus decoded-frame outputs of the frame decoder.
// master = SPI host / consumer side, slave = decoder side.
interface spi_frame_decoder_if #(
    parameter int FRAME_W = 16
);
    logic               sclk;
    logic               cs_n;
    logic               mosi;
    logic               miso;
    logic [FRAME_W-1:0] tx_data;
    logic [FRAME_W-1:0] fields_o;
    logic               frame_valid;
    logic               frame_err;
    logic               busy;

    modport master (
        output sclk, cs_n, mosi, tx_data,
        input  miso, fields_o, frame_valid, frame_err, busy
    );

    modport slave (
        input  sclk, cs_n, mosi, tx_data,
        output miso, fields_o, frame_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with one extra registered copy for
// single-cycle rise/fall pulses in the clk domain.
module spi_sync_edge
    import spi_frame_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // Clearing to 0 means a cs_n held low through reset never looks like a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_frame_decoder.sv
// Oversampling SPI mode-0 slave: shifts a FRAME_W-bit word from mosi,
// checks its length and publishes it atomically as NUM_FIELDS fields.
module spi_frame_decoder
    import spi_frame_pkg::*;
#(
    parameter int FIELD_W     = 4,
    parameter int NUM_FIELDS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                rst,
    spi_frame_decoder_if.slave bus
);
    localparam int FRAME_W = frame_w(FIELD_W, NUM_FIELDS);
    localparam int CW      = cnt_w(FRAME_W);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s;

    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [FRAME_W-1:0] rx_q, rx_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [FRAME_W-1:0] fields_q, fields_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.sclk),
        .q    (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.cs_n),
        .q    (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // Same depth as the sclk chain so mosi_s lines up with sclk_rise.
    assign mosi_d = {mosi_q[SYNC_STAGES-2:0], bus.mosi};
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        fields_d = fields_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        busy_d   = busy_q;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    cnt_d   = '0;
                    rx_d    = '0;
                    tx_d    = bus.tx_data;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_d = {rx_q[FRAME_W-2:0], mosi_s};
                    if (cnt_q != CW'(FRAME_W + 1))
                        cnt_d = cnt_q + CW'(1);
                end
                if (sclk_fall)
                    tx_d = {tx_q[FRAME_W-2:0], 1'b0};
                // Frame end sees this cycle's shift, so use the _d values.
                if (cs_rise) begin
                    if (cnt_d == CW'(FRAME_W)) begin
                        fields_d = rx_d;
                        valid_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    tx_d    = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            WAIT_CS: begin
                tx_d   = '0;
                busy_d = 1'b0;
                if (cs_s && !sclk_s)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            fields_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            mosi_q   <= mosi_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            fields_q <= fields_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.miso        = tx_q[FRAME_W-1];
    assign bus.fields_o    = fields_q;
    assign bus.frame_valid = valid_q;
    assign bus.frame_err   = err_q;
    assign bus.busy        = busy_q;

endmodule
